nv_ram_rwsp_mask_init: RTL and testbench
========================================

Name: nv_ram_rwsp_mask_init

Overview:
- Parametrised successor to the fixed 2-port register-file RAM models: one write port, one read port, with registered read address and registered output stage.
- Adds parametrised width and depth, per-lane write mask, and an optional write-to-read bypass.
- Adds a post-reset clear sequencer that zeroes every entry, and a read-valid flag.
- Used as a generic small buffer (credit/ptr tables, small FIFOs) inside NVDLA core-clock subunits.

Parameters:
- DEPTH, 4, number of entries; 2..1024, need not be a power of two.
- AW, 2, address width; must satisfy 2^AW >= DEPTH.
- WIDTH, 128, data width in bits; must be a multiple of LANE_W.
- LANE_W, 8, bits per write-mask lane; mask width MW = WIDTH/LANE_W.
- BYPASS, 0, 1 = write-first forwarding on a same-address collision at the output stage; 0 = read-old.
- FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, 1'b0, kept for model compatibility; no functional effect.

Ports:
- nvdla_core_clk, input, 1, single clock; all state on the rising edge.
- nvdla_core_rstn, input, 1, asynchronous active-low reset.
- ra, input, AW, read address.
- re, input, 1, read-address capture enable.
- ore, input, 1, output-register capture enable.
- dout, output, WIDTH, registered read data.
- dout_vld, output, 1, dout updated this cycle by a pending read.
- wa, input, AW, write address.
- we, input, 1, write enable.
- wmask, input, MW, per-lane write enable; lane i covers di[i*LANE_W +: LANE_W].
- di, input, WIDTH, write data.
- pwrbus_ram_pd, input, 32, power-bus tie; ignored functionally.
- init_busy, output, 1, clear sequence in progress; no access is accepted while high.

Behaviour:
- Reset (async assert, any time, including mid-clear or mid-read):
  - init_busy=1, dout=0, dout_vld=0.
  - Internal ra_d=0, rd_pend=0, clear pointer=0.
  - FSM goes to CLEAR. Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes all-zero to M[clr_ptr] and increments clr_ptr.
  - When clr_ptr==DEPTH-1 is written, the next state is READY.
  - Clear takes exactly DEPTH cycles after the first clock edge following rstn deassertion.
  - re, we and ore are ignored; dout holds 0 and dout_vld holds 0.
- FSM READY: init_busy=0. Stays in READY until reset.
- Write, when READY, we=1 and wa<DEPTH:
  - M[wa] lane i <= di lane i only where wmask[i]=1; other lanes unchanged.
  - we with wa>=DEPTH is dropped silently.
  - wmask=0 is a no-op.
- Read pipeline:
  - Cycle N: re=1 (READY) captures ra_d<=ra and sets rd_pend=1.
  - Cycle N+1 or later: ore=1 captures dout<=word(ra_d) and sets dout_vld=1 the following cycle.
  - rd_pend clears unless re is also high that cycle.
  - Minimum read latency is 2 edges.
  - ore without rd_pend still recaptures dout (legacy behaviour) but leaves dout_vld=0.
  - dout_vld is a 1-cycle pulse per capture.
  - re while rd_pend=1 overwrites ra_d; the earlier read is lost and no error is flagged.
- word(ra_d):
  - Equals M[ra_d] if ra_d<DEPTH, else all-zero.
  - When BYPASS=1, we=1 and wa==ra_d in the ore cycle: masked lanes come from di, others from M.
  - When BYPASS=0 in that case: old M contents.
- Simultaneous re/we to the same address in one cycle: the write commits; the later ore returns the new data regardless of BYPASS.
- Width rules: no arithmetic on data; clr_ptr is AW bits wide and never exceeds DEPTH-1.

Test Plan:
- Clear sequence, DEPTH=4:
  - Release rstn, then count edges -> init_busy high for exactly 4 cycles.
  - Then read all 4 entries -> each returns 0x0 with dout_vld=1.
- Masked write, WIDTH=128, LANE_W=8:
  - Write wa=2, di=all-ones, wmask=16'hFFFF.
  - Then write wa=2, di=0, wmask=16'h00F0.
  - Read addr 2 -> dout=128'hFFFF...FFFF_FFFF_0000_0000_FFFF_FFFF; dout_vld one cycle after ore.
- Collision:
  - re addr 1 in cycle N.
  - In cycle N+1, ore=1 and we=1 to wa=1 with di=0xA5.. and full mask.
  - Expect BYPASS=1 -> dout=0xA5..; BYPASS=0 -> prior contents of entry 1.
- Non-power-of-two, DEPTH=5, AW=3:
  - Write wa=6 -> no entry changes.
  - Read ra=6 -> dout=0, dout_vld=1.
  - Clear lasts 5 cycles.
- Reset mid-clear and mid-read:
  - Assert rstn low at clear cycle 2 -> outputs 0 immediately (async), and the clear restarts from entry 0.
  - Assert rstn low between re and ore -> dout_vld never pulses for that read.
- Back-to-back reads:
  - re on consecutive cycles to addrs 0,1,2 with ore every cycle -> dout shows entries 0,1,2 on successive cycles.
  - dout_vld stays high for 3 cycles.

Source files
------------

// File: rtl/nv_ram_rwsp_mask_init.sv
// One-write/one-read register-file RAM with per-lane write mask, registered
// read address and output stages, optional write-first bypass and a post-reset clear.
module nv_ram_rwsp_mask_init #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2,
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned LANE_W = 8,
  parameter bit          BYPASS = 1'b0,
  parameter bit          FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic [AW-1:0]             ra,
  input  logic                      re,
  input  logic                      ore,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_vld,
  input  logic [AW-1:0]             wa,
  input  logic                      we,
  input  logic [WIDTH/LANE_W-1:0]   wmask,
  input  logic [WIDTH-1:0]          di,
  input  logic [31:0]               pwrbus_ram_pd,
  output logic                      init_busy
);

  localparam int unsigned MW = WIDTH / LANE_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic              rd_pend_q, rd_pend_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  rd_word;
  logic              ready, wa_ok, ra_ok;

  logic unused_ok;
  assign unused_ok = ^{pwrbus_ram_pd, FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};

  always_comb begin
    ready  = (state_q == ST_READY);
    wa_ok  = (32'(wa) < DEPTH);
    ra_ok  = (32'(ra_q) < DEPTH);
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = '0;
    if (!ready) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr_q;
    end else if (we && wa_ok) begin
      // Masked write is done as read-merge-write of the whole word.
      mem_we = 1'b1;
      mem_wd = mem_q[wa];
      for (int unsigned i = 0; i < MW; i++) begin
        if (wmask[i]) mem_wd[i*LANE_W +: LANE_W] = di[i*LANE_W +: LANE_W];
      end
    end

    rd_word = ra_ok ? mem_q[ra_q] : '0;
    // The merged write word is exactly the write-first view of the colliding entry.
    if (BYPASS && ready && we && wa_ok && (wa == ra_q)) rd_word = mem_wd;
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ra_d       = ra_q;
    rd_pend_d  = rd_pend_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = ST_READY;
        else                             clr_ptr_d = clr_ptr_q + AW'(1);
      end
      ST_READY: begin
        if (ore) begin
          dout_d     = rd_word;
          dout_vld_d = rd_pend_q;
          rd_pend_d  = 1'b0;
        end
        if (re) begin
          ra_d      = ra;
          rd_pend_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      ra_q       <= '0;
      rd_pend_q  <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ra_q       <= ra_d;
      rd_pend_q  <= rd_pend_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign init_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_nv_ram_rwsp_mask_init.sv
// Bench for nv_ram_rwsp_mask_init: three instances (DEPTH=4 read-old, DEPTH=4
// write-first, DEPTH=5) share stimulus; a transaction model feeds a scoreboard.
module tb_nv_ram_rwsp_mask_init;

  localparam logic [127:0] ALL1 = '1;
  localparam logic [127:0] PAT  = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
  localparam logic [127:0] V1   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] A5   = {16{8'hA5}};

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [2:0]        ra = '0, wa = '0;
  logic              re = 1'b0, ore = 1'b0, we = 1'b0;
  logic [15:0]       wmask = '0;
  logic [127:0]      di = '0;
  logic [31:0]       pwr = '0;
  logic [2:0][127:0] dout_w;
  logic [2:0]        vld_w, busy_w;

  always #5 clk = ~clk;

  nv_ram_rwsp_mask_init #(.DEPTH(4), .AW(2), .WIDTH(128), .LANE_W(8), .BYPASS(1'b0)) u_d4 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra[1:0]), .re(re), .ore(ore),
    .dout(dout_w[0]), .dout_vld(vld_w[0]), .wa(wa[1:0]), .we(we), .wmask(wmask), .di(di),
    .pwrbus_ram_pd(pwr), .init_busy(busy_w[0]));

  nv_ram_rwsp_mask_init #(.DEPTH(4), .AW(2), .WIDTH(128), .LANE_W(8), .BYPASS(1'b1)) u_d4b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra[1:0]), .re(re), .ore(ore),
    .dout(dout_w[1]), .dout_vld(vld_w[1]), .wa(wa[1:0]), .we(we), .wmask(wmask), .di(di),
    .pwrbus_ram_pd(pwr), .init_busy(busy_w[1]));

  nv_ram_rwsp_mask_init #(.DEPTH(5), .AW(3), .WIDTH(128), .LANE_W(8), .BYPASS(1'b0)) u_d5 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_w[2]), .dout_vld(vld_w[2]), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .pwrbus_ram_pd(pwr), .init_busy(busy_w[2]));

  int unsigned depth_m [3] = '{4, 4, 5};
  logic [2:0]  amask_m [3] = '{3'd3, 3'd3, 3'd7};
  bit          byp_m   [3] = '{1'b0, 1'b1, 1'b0};

  logic [127:0] mem_m  [3][8];
  logic [2:0]   ra_m   [3];
  bit           pend_m [3];
  logic [127:0] dout_m [3];

  typedef struct packed {
    logic [2:0][127:0] d;
    logic [2:0]        v;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic r; logic [2:0] ra; logic o; logic w; logic [2:0] wa;
    logic [15:0] m; logic [127:0] d; logic ev; logic [127:0] ed;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) mem_m[k][a] = '0;
      ra_m[k] = '0; pend_m[k] = 1'b0; dout_m[k] = '0;
    end
  endtask

  function automatic logic [127:0] word_m(input int k, input logic [2:0] a);
    return (int'(a) < int'(depth_m[k])) ? mem_m[k][a] : '0;
  endfunction

  task automatic step(input logic r, input logic [2:0] ra_i, input logic o, input logic w,
                      input logic [2:0] wa_i, input logic [15:0] m, input logic [127:0] d);
    exp_t e, got;
    @(negedge clk);
    re = r; ra = ra_i; ore = o; we = w; wa = wa_i; wmask = m; di = d;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] wk;
      wk = wa_i & amask_m[k];
      e.v[k] = 1'b0;
      if (o) begin
        dout_m[k] = word_m(k, ra_m[k]);
        if (byp_m[k] && w && wk == ra_m[k] && int'(wk) < int'(depth_m[k]))
          for (int l = 0; l < 16; l++) if (m[l]) dout_m[k][l*8 +: 8] = d[l*8 +: 8];
        e.v[k] = pend_m[k];
        pend_m[k] = 1'b0;
      end
      e.d[k] = dout_m[k];
      if (w && int'(wk) < int'(depth_m[k]))
        for (int l = 0; l < 16; l++) if (m[l]) mem_m[k][wk][l*8 +: 8] = d[l*8 +: 8];
      if (r) begin ra_m[k] = ra_i & amask_m[k]; pend_m[k] = 1'b1; end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dout[%0d]", k), dout_w[k], got.d[k]);
      chk($sformatf("dout_vld[%0d]", k), {127'd0, vld_w[k]}, {127'd0, got.v[k]});
    end
    re = 1'b0; ore = 1'b0; we = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_busy[%0d]", tag, k), {127'd0, busy_w[k]}, 128'd1);
      chk($sformatf("%s_dout[%0d]", tag, k), dout_w[k], '0);
      chk($sformatf("%s_vld[%0d]", tag, k), {127'd0, vld_w[k]}, '0);
    end
    model_reset();
  endtask

  // Releases reset at a falling edge and counts rising edges until each instance is ready.
  task automatic release_and_clear(input string tag);
    int cnt [3];
    bit done [3];
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; done[k] = 1'b0;
      chk($sformatf("%s_busy_rel[%0d]", tag, k), {127'd0, busy_w[k]}, 128'd1);
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (!done[k] && !busy_w[k]) begin done[k] = 1'b1; cnt[k] = n; end
      if (done[0] && done[1] && done[2]) break;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_clear_len[%0d]", tag, k), 128'(cnt[k]), 128'(depth_m[k]));
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{0, 0, 0, 1, 2, 16'hFFFF, ALL1, 0, '0};
    tbl[1] = '{0, 0, 0, 1, 2, 16'h00F0, '0,   0, '0};
    tbl[2] = '{1, 2, 0, 0, 0, 16'h0000, '0,   0, '0};
    tbl[3] = '{0, 0, 1, 0, 0, 16'h0000, '0,   1, PAT};
    tbl[4] = '{0, 0, 0, 0, 0, 16'h0000, '0,   0, PAT};
    tbl[5] = '{1, 1, 0, 1, 1, 16'hFFFF, V1,   0, PAT};
    tbl[6] = '{0, 0, 1, 0, 0, 16'h0000, '0,   1, V1};
    tbl[7] = '{0, 0, 1, 0, 0, 16'h0000, '0,   0, V1};
    tbl[8] = '{1, 0, 0, 1, 0, 16'h0000, ALL1, 0, V1};
    tbl[9] = '{0, 0, 1, 0, 0, 16'h0000, '0,   1, '0};

    model_reset();
    #2;
    async_reset_check("por");
    release_and_clear("init");

    // Empty-after-clear: every entry of each instance reads back as zero.
    for (int a = 0; a < 5; a++) begin
      step(1, 3'(a), 0, 0, 0, '0, '0);
      step(0, 0, 1, 0, 0, '0, '0);
      chk($sformatf("clr_rd%0d", a), dout_w[2], '0);
      chk($sformatf("clr_vld%0d", a), {127'd0, vld_w[2]}, 128'd1);
    end

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].ra, tbl[i].o, tbl[i].w, tbl[i].wa, tbl[i].m, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), dout_w[0], tbl[i].ed);
      chk($sformatf("tbl%0d_vld", i), {127'd0, vld_w[0]}, {127'd0, tbl[i].ev});
    end

    // Read/write collision in the output-capture cycle.
    step(1, 1, 0, 0, 0, '0, '0);
    step(0, 0, 1, 1, 1, 16'hFFFF, A5);
    chk("coll_old", dout_w[0], V1);
    chk("coll_byp", dout_w[1], A5);

    // Back-to-back reads: entries 0,1,2 on consecutive cycles.
    step(1, 0, 0, 0, 0, '0, '0);
    step(1, 1, 1, 0, 0, '0, '0);
    chk("b2b_e0", dout_w[0], '0);
    chk("b2b_v0", {127'd0, vld_w[0]}, 128'd1);
    step(1, 2, 1, 0, 0, '0, '0);
    chk("b2b_e1", dout_w[0], A5);
    chk("b2b_v1", {127'd0, vld_w[0]}, 128'd1);
    step(0, 0, 1, 0, 0, '0, '0);
    chk("b2b_e2", dout_w[0], PAT);
    chk("b2b_v2", {127'd0, vld_w[0]}, 128'd1);
    step(0, 0, 0, 0, 0, '0, '0);
    chk("b2b_vend", {127'd0, vld_w[0]}, '0);

    // Out-of-range write and read on the DEPTH=5 instance.
    step(0, 0, 0, 1, 6, 16'hFFFF, ALL1);
    step(1, 6, 0, 0, 0, '0, '0);
    step(0, 0, 1, 0, 0, '0, '0);
    chk("oor_dout", dout_w[2], '0);
    chk("oor_vld", {127'd0, vld_w[2]}, 128'd1);
    for (int a = 0; a < 5; a++) begin
      step(1, 3'(a), 0, 0, 0, '0, '0);
      step(0, 0, 1, 0, 0, '0, '0);
    end

    // Reset between re and ore: the pending read is discarded.
    step(1, 1, 0, 0, 0, '0, '0);
    step(1, 2, 1, 0, 0, '0, '0);
    chk("pre_rst_dout", dout_w[0], A5);
    @(negedge clk);
    async_reset_check("midrd");
    release_and_clear("midrd");
    step(0, 0, 1, 0, 0, '0, '0);
    chk("midrd_novld", {127'd0, vld_w[0]}, '0);

    // Reset during clear cycle 2: the clear restarts at entry 0.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    async_reset_check("midclr");
    release_and_clear("midclr");
    for (int a = 0; a < 4; a++) begin
      step(1, 3'(a), 0, 0, 0, '0, '0);
      step(0, 0, 1, 0, 0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
